// File: rtl/dp_fifo.sv
// Single-clock FIFO: write port A, read port B, registered read data,
// registered status flags, occupancy count and one-cycle overflow/underflow pulses.
module dp_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             din,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_full;
  logic             r_empty;
  logic             r_afull;
  logic             r_ovf;
  logic             r_udf;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [CW-1:0]    w_cnt_nxt;

  // A write into a full buffer is still accepted when a read frees a slot this cycle.
  assign w_rd_acc = rd_en & ~r_empty;
  assign w_wr_acc = wr_en & (~r_full | w_rd_acc);

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)
      w_cnt_nxt = r_count + 1'b1;
    else if (w_rd_acc && !w_wr_acc)
      w_cnt_nxt = r_count - 1'b1;
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_afull      <= 1'b0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= r_mem[r_rd_ptr];
      end
      r_dout_valid <= w_rd_acc;
      r_count      <= w_cnt_nxt;
      r_full       <= (w_cnt_nxt == CW'(DEPTH));
      r_empty      <= (w_cnt_nxt == '0);
      r_afull      <= (w_cnt_nxt >= CW'(AFULL_LEVEL));
      r_ovf        <= wr_en & ~w_wr_acc;
      r_udf        <= rd_en & ~w_rd_acc;
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_afull;
  assign count       = r_count;
  assign overflow    = r_ovf;
  assign underflow   = r_udf;

endmodule

// File: tb/tb_dp_fifo.sv
// Directed bench for dp_fifo: a queue reference model plus a read scoreboard,
// every output compared each cycle one time unit after the rising edge.
module tb_dp_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid, full, empty, almost_full, overflow, underflow;
  logic [4:0]       count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] last_dout = '0;

  dp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input bit ovf, input bit udf, input bit vld);
    int sz;
    sz = mq.size();
    chk("count", 32'(count), 32'(sz));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("almost_full", 32'(almost_full), 32'(sz >= AFULL));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("underflow", 32'(underflow), 32'(udf));
    chk("dout_valid", 32'(dout_valid), 32'(vld));
  endtask

  // One clock of stimulus; the model decides acceptance before the edge.
  task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r);
    bit ra, wa;
    ra = r && (mq.size() > 0);
    wa = w && ((mq.size() < DEPTH) || ra);
    wr_en = w;
    din   = d;
    rd_en = r;
    if (ra) sb.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_flags(w && !wa, r && !ra, ra);
    if (ra) begin
      last_dout = sb.pop_front();
      chk("dout", 32'(dout), 32'(last_dout));
    end else begin
      chk("dout_hold", 32'(dout), 32'(last_dout));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_flags(1'b0, 1'b0, 1'b0);
    chk("rst_dout", 32'(dout), 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check_flags(1'b0, 1'b0, 1'b0);

    // Fill 0..15 then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Refill, reject a write while full, then read+write while full.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(8'h20 + i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Read and write together while empty: write lands, read rejected.
    cycle(1'b1, 8'h55, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Interleaved traffic around count 3..4 so both pointers wrap twice.
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0:       cycle(1'b1, WIDTH'($urandom), 1'b0);
        2:       cycle(1'b0, '0, 1'b1);
        default: cycle(1'b1, WIDTH'($urandom), 1'b1);
      endcase
    end
    while (mq.size() > 0) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Asynchronous reset with five words held and a read in flight.
    for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(8'hC0 + i), 1'b0);
    wr_en = 1'b0;
    rd_en = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    rd_en = 1'b0;
    mq.delete();
    sb.delete();
    last_dout = '0;
    check_flags(1'b0, 1'b0, 1'b0);
    chk("arst_dout", 32'(dout), 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check_flags(1'b0, 1'b0, 1'b0);

    // Still operational after reset.
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
